instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the RV32 core: owns the fetch PC and issues word fetch requests to instruction memory.
//  Buffers in-order responses and presents {pc, instr} to decode over a valid/ready handshake.
//  Redirects from execute (branch/jump) flush the buffer and discard in-flight responses.
//  Replaces the bare PC register and +4 adder as the producer of the fetch address.
// PARAMETERS
//  RESET_PC      32'h00000000  fetch address after reset
//  FIFO_DEPTH    2             instruction buffer entries (power of 2, >=2)
//  MAX_OUTSTD    2             max accepted-but-unanswered imem requests (<= FIFO_DEPTH)
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word fetch address
//  imem_rsp_valid  in   1   response valid; in order, >=1 cycle after acceptance, never back-pressured
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken, one-cycle pulse
//  redirect_pc     in   32  redirect target
//  if_valid        out  1   instruction available to decode
//  if_ready        in   1   decode accepts
//  if_pc           out  32  PC of presented instruction
//  if_instr        out  32  presented instruction
//  if_exc          out  1   misaligned-target fault (IFU_MISALIGN_TRAP_EN only; else tied 0)
// BEHAVIOUR
//  Reset: pc=RESET_PC; imem_req_valid=0, if_valid=0, if_exc=0; fifo empty; outstd=0; drop_cnt=0; state=IDLE.
//  Responses arriving in IDLE are ignored. Reset mid-operation discards all state immediately.
//  FSM: IDLE -> FETCH (unconditional, 1 cycle after reset release).
//   FETCH: redirect with outstd(after this cycle's events)>0 -> DRAIN; otherwise remain.
//   DRAIN: no requests issued; each response decrements drop_cnt and is discarded; drop_cnt==0 -> FETCH.
//  Request: imem_req_valid=1 in FETCH when outstd + fifo_count < FIFO_DEPTH and outstd < MAX_OUTSTD.
//   Address = pc; addr stable while valid && !ready. Accept (valid&&ready): outstd+1, pc <= pc+4 (mod 2^32, wraps to 0).
//   Retraction of an unaccepted request is permitted only in a redirect cycle.
//  Response in FETCH: push {pc_of_req, data}; outstd-1. Credit rule guarantees no overflow.
//   Request PCs are tracked in a parallel tag fifo (or derived from pc - 4*pending).
//  Decode side: if_valid = fifo non-empty; pop on if_valid && if_ready; push+pop same cycle allowed.
//   if_pc/if_instr stable while if_valid && !if_ready. Latency: response cycle -> if_valid next cycle.
//  Redirect (highest priority): pc <= redirect_pc; fifo flushed; if_valid=0 next cycle;
//   imem_req_valid=0 in the redirect cycle. Any request accepted that cycle and all in-flight requests,
//   minus any response arriving that same cycle (discarded), load drop_cnt. A redirect in DRAIN reloads pc
//   and keeps the existing drop_cnt plus newly accepted requests.
//  Decode pop in a redirect cycle completes (decode accepted it) before the flush.
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined: redirect_pc[1:0]!=0 -> no fetch.
//   After drain, present one entry {if_pc=redirect_pc, if_instr=32'h00000013, if_exc=1}.
//   After it pops, stall in FETCH without requests until the next redirect.
//  Not defined: redirect_pc[1:0] forced to 2'b00; if_exc tied 0.
// STRUCTURE
//  Shared header ifu_defs.vh: FSM state encodings (IDLE/FETCH/DRAIN), NOP=32'h00000013, PC_INC=32'd4.
//  One sub-module: ifu_fifo (sync FIFO, width 64, depth FIFO_DEPTH, flush input, count output).
//  Counters outstd/drop_cnt sized $clog2(MAX_OUTSTD+1).
// TESTING
//  1 Reset release, ready=1, 1-cycle rsp latency, if_ready=1 -> if_pc 0,4,8,C back-to-back; first if_valid cycle 3.
//  2 if_ready=0 for 10 cycles -> exactly FIFO_DEPTH fetches (pc 0,4); requests stall; no drop; resume in order.
//  3 2 requests outstanding, redirect_pc=32'h100 -> DRAIN; both responses discarded; next if_pc=32'h100.
//  4 RESET_PC=32'hFFFFFFF8 -> if_pc FFFFFFF8, FFFFFFFC, 00000000 (wrap).
//  5 Redirect in same cycle as response and as decode pop -> popped instr delivered once, response dropped,
//    no stale if_valid.
//  6 (IFU_MISALIGN_TRAP_EN) redirect_pc=32'h102 -> single if_exc=1 entry, if_pc=32'h102, then no requests
//    until next redirect.
//  Assert throughout: no fifo overflow; outstd<=MAX_OUTSTD; imem_req_addr stable while stalled.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states, buffer entry layout,
// the canonical NOP and the sequential fetch increment.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } ifu_state_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifu_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

    // Fault entry presented to decode for a misaligned redirect target.
    function automatic ifu_entry_t trap_entry(input logic [31:0] pc);
        return '{pc: pc, instr: NOP};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the imem request/response, redirect and decode handshakes of the fetch unit.
// master = fetch unit side, slave = memory/execute/decode environment side.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_exc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr, if_exc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// ifu_fifo: first-word-fall-through synchronous FIFO with flush and occupancy count.
// A push into a full FIFO is dropped; the fetch credit scheme keeps that from happening.
module ifu_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en, pop_en;

    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign push_en    = push_i && !flush_i && (count_q != CW'(DEPTH));
    assign pop_en     = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch front end: owns the fetch PC, issues credit-limited imem requests, buffers in-order
// responses for decode and drains stale responses after a redirect. Option: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_OUTSTD = 2
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned OCW = $clog2(MAX_OUTSTD + 1);
    localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);

    ifu_state_e     state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [OCW-1:0] outstd_q, outstd_d, drop_q, drop_d;
    logic [OCW-1:0] outstd_evt, drop_evt;
    logic           req_valid, acc, rsp, redir, fetch_en;
    logic           fifo_push, fifo_pop, fifo_flush, fifo_empty;
    logic [FCW-1:0] fifo_count;
    logic [31:0]    redir_target, rsp_tag, credit_used;
    ifu_entry_t     push_entry, head_entry;

    assign acc   = req_valid && bus.imem_req_ready;
    assign rsp   = bus.imem_rsp_valid;
    assign redir = bus.redirect_valid;

    assign outstd_evt  = outstd_q + OCW'(acc) - OCW'(rsp);
    assign drop_evt    = drop_q - OCW'(rsp);
    assign credit_used = 32'(outstd_q) + 32'(fifo_count);
    // The oldest live request sits outstd entries behind the current fetch PC.
    assign rsp_tag     = pc_q - (32'(outstd_q) << 2);
    assign push_entry  = '{pc: rsp_tag, instr: bus.imem_rsp_data};

    assign req_valid = (state_q == ST_FETCH) && !redir && fetch_en &&
                       (credit_used < FIFO_DEPTH) && (32'(outstd_q) < MAX_OUTSTD);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        outstd_d   = outstd_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (acc) pc_d = pc_q + PC_INC;
                outstd_d  = outstd_evt;
                fifo_push = rsp && !redir;
                if (redir) begin
                    pc_d       = redir_target;
                    fifo_flush = 1'b1;
                    outstd_d   = '0;
                    if (outstd_evt != '0) begin
                        drop_d  = outstd_evt;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drop_d = drop_evt;
                if (redir) begin
                    pc_d       = redir_target;
                    fifo_flush = 1'b1;
                end
                if (drop_evt == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            outstd_q <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            outstd_q <= outstd_d;
            drop_q   <= drop_d;
        end
    end

    ifu_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (fifo_flush),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_entry),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign fifo_pop = bus.if_ready && !fifo_empty;

`ifdef IFU_MISALIGN_TRAP_EN
    logic        halt_q, halt_d, exc_pend_q, exc_pend_d, exc_valid_q, exc_valid_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    ifu_entry_t  exc_entry;

    assign redir_target = bus.redirect_pc;
    assign fetch_en     = !halt_q;
    assign exc_entry    = trap_entry(exc_pc_q);

    // The fault entry only appears once stale responses are drained (state back in FETCH).
    always_comb begin
        halt_d      = halt_q;
        exc_pend_d  = exc_pend_q;
        exc_valid_d = exc_valid_q;
        exc_pc_d    = exc_pc_q;
        if (redir) begin
            halt_d      = (redir_target[1:0] != 2'b00);
            exc_pend_d  = (redir_target[1:0] != 2'b00);
            exc_valid_d = 1'b0;
            exc_pc_d    = redir_target;
        end else begin
            if (exc_valid_q && bus.if_ready) exc_valid_d = 1'b0;
            if (exc_pend_q && state_q == ST_FETCH) begin
                exc_pend_d  = 1'b0;
                exc_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_q      <= 1'b0;
            exc_pend_q  <= 1'b0;
            exc_valid_q <= 1'b0;
            exc_pc_q    <= '0;
        end else begin
            halt_q      <= halt_d;
            exc_pend_q  <= exc_pend_d;
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
        end
    end

    assign bus.if_valid = exc_valid_q || !fifo_empty;
    assign bus.if_pc    = exc_valid_q ? exc_entry.pc    : head_entry.pc;
    assign bus.if_instr = exc_valid_q ? exc_entry.instr : head_entry.instr;
    assign bus.if_exc   = exc_valid_q;
`else
    assign redir_target = word_align(bus.redirect_pc);
    assign fetch_en     = 1'b1;
    assign bus.if_valid = !fifo_empty;
    assign bus.if_pc    = head_entry.pc;
    assign bus.if_instr = head_entry.instr;
    assign bus.if_exc   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory model answers accepted requests in order, and a
// stream model expects decode to see consecutive PCs from each redirect target with matching words.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned MAXO  = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .MAX_OUTSTD (MAXO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mreq_t       memq[$];
    int          cyc, n_cmp, n_err, pops, acc_cnt, last_due;
    int          p_ready, p_ifr, lat_min, lat_max;
    logic [31:0] exp_pc;
    logic        watch_wrap, saw_wrap, auto_combo, combo_hit;
    logic        prev_req_valid, prev_req_ready, prev_redir, prev_if_valid, prev_if_ready;
    logic [31:0] prev_addr, prev_if_pc, prev_if_instr;
    logic        obs_if_valid;
    logic [31:0] obs_if_pc;
`ifdef IFU_MISALIGN_TRAP_EN
    logic        exp_trap, halted;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_redirect(input logic [31:0] tgt);
`ifdef IFU_MISALIGN_TRAP_EN
        exp_pc   = tgt;
        exp_trap = (tgt[1:0] != 2'b00);
        halted   = exp_trap;
`else
        exp_pc = tgt & ~32'h3;
`endif
    endtask

    task automatic model_pop();
        pops++;
`ifdef IFU_MISALIGN_TRAP_EN
        if (exp_trap) begin
            check_eq("exc_flag", 32'(bus.if_exc), 32'd1);
            check_eq("exc_pc", bus.if_pc, exp_pc);
            check_eq("exc_instr", bus.if_instr, NOP);
            exp_trap = 1'b0;
        end else if (halted) begin
            check_eq("pop_while_halted", 32'(bus.if_valid), 32'd0);
        end else
`endif
        begin
            check_eq("if_pc", bus.if_pc, exp_pc);
            check_eq("if_instr", bus.if_instr, mem_word(exp_pc));
            check_eq("if_exc", 32'(bus.if_exc), 32'd0);
            if (watch_wrap && exp_pc == 32'h0) saw_wrap = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // One clock: drive inputs at the falling edge, observe and score 1 time unit later.
    task automatic step(input logic redir, input logic [31:0] tgt);
        logic        acc, redir_l;
        logic [31:0] tgt_l;
        int          d;
        @(negedge clk);
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.if_ready       = ($urandom_range(99) < p_ifr);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom;
        end
        redir_l = redir;
        tgt_l   = tgt;
        if (auto_combo && bus.if_valid && bus.if_ready && bus.imem_rsp_valid) begin
            redir_l    = 1'b1;
            tgt_l      = 32'h0000_0300;
            auto_combo = 1'b0;
            combo_hit  = 1'b1;
        end
        bus.redirect_valid = redir_l;
        bus.redirect_pc    = tgt_l;
        #1;
        if (prev_redir) check_eq("stale_if_valid", 32'(bus.if_valid), 32'd0);
        if (prev_req_valid && !prev_req_ready && !redir_l) begin
            check_eq("req_valid_hold", 32'(bus.imem_req_valid), 32'd1);
            check_eq("req_addr_hold", bus.imem_req_addr, prev_addr);
        end
        if (prev_if_valid && !prev_if_ready && !prev_redir) begin
            check_eq("if_valid_hold", 32'(bus.if_valid), 32'd1);
            check_eq("if_pc_hold", bus.if_pc, prev_if_pc);
            check_eq("if_instr_hold", bus.if_instr, prev_if_instr);
        end
        acc = bus.imem_req_valid && bus.imem_req_ready;
        if (bus.imem_rsp_valid) void'(memq.pop_front());
        if (acc) begin
`ifdef IFU_MISALIGN_TRAP_EN
            if (halted) check_eq("req_while_halted", 32'(acc), 32'd0);
`endif
            acc_cnt++;
            d = cyc + int'($urandom_range(lat_min, lat_max));
            if (d < last_due) d = last_due;
            last_due = d;
            memq.push_back('{addr: bus.imem_req_addr, due: d});
            check_eq("outstanding_le_max", 32'(memq.size() <= MAXO), 32'd1);
        end
        if (bus.if_valid && bus.if_ready) model_pop();
        if (redir_l) model_redirect(tgt_l);
        obs_if_valid   = bus.if_valid;
        obs_if_pc      = bus.if_pc;
        prev_req_valid = bus.imem_req_valid;
        prev_req_ready = bus.imem_req_ready;
        prev_addr      = bus.imem_req_addr;
        prev_redir     = redir_l;
        prev_if_valid  = bus.if_valid;
        prev_if_ready  = bus.if_ready;
        prev_if_pc     = bus.if_pc;
        prev_if_instr  = bus.if_instr;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst                = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.if_ready       = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check_eq("rst_if_exc", 32'(bus.if_exc), 32'd0);
        memq.delete();
        exp_pc         = 32'h0;
        last_due       = 0;
        prev_req_valid = 1'b0;
        prev_req_ready = 1'b0;
        prev_redir     = 1'b0;
        prev_if_valid  = 1'b0;
        prev_if_ready  = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        exp_trap = 1'b0;
        halted   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          first_cyc, pops_before;
        logic        got;
        logic [31:0] tgt;
        n_cmp = 0; n_err = 0; cyc = 0; pops = 0; acc_cnt = 0;
        watch_wrap = 1'b0; saw_wrap = 1'b0; auto_combo = 1'b0; combo_hit = 1'b0;
        p_ready = 100; p_ifr = 100; lat_min = 1; lat_max = 1;
        do_reset();

        // Back-to-back ready system: first instruction visible three clocks after release.
        first_cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 32'h0);
            if (first_cyc < 0 && obs_if_valid) first_cyc = i;
        end
        check_eq("first_valid_cycle", 32'(first_cyc), 32'd3);

        // Decode stalled: exactly DEPTH fetches after the redirect, then requests stop.
        p_ifr = 0; lat_max = 3;
        step(1'b1, 32'h0000_0200);
        acc_cnt = 0;
        repeat (30) step(1'b0, 32'h0);
        check_eq("stall_fetch_count", 32'(acc_cnt), DEPTH);
        check_eq("stall_head_valid", 32'(obs_if_valid), 32'd1);
        check_eq("stall_head_pc", obs_if_pc, 32'h0000_0200);
        p_ifr = 100;
        repeat (10) step(1'b0, 32'h0);

        // Redirect with two requests in flight: both responses must be discarded.
        lat_min = 6; lat_max = 6;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            step(1'b0, 32'h0);
            got = (memq.size() == 2);
        end
        check_eq("two_outstanding", 32'(got), 32'd1);
        step(1'b1, 32'h0000_0100);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            step(1'b0, 32'h0);
            got = obs_if_valid;
        end
        check_eq("redirect_valid_seen", 32'(got), 32'd1);
        check_eq("redirect_first_pc", obs_if_pc, 32'h0000_0100);
        repeat (10) step(1'b0, 32'h0);

        // PC wrap across 2^32.
        lat_min = 1; lat_max = 2; watch_wrap = 1'b1;
        step(1'b1, 32'hFFFF_FFF8);
        repeat (30) step(1'b0, 32'h0);
        watch_wrap = 1'b0;
        check_eq("pc_wrap_seen", 32'(saw_wrap), 32'd1);

        // Redirect coinciding with a response and a decode pop.
        lat_min = 1; lat_max = 1; auto_combo = 1'b1;
        for (int i = 0; i < 100 && auto_combo; i++) step(1'b0, 32'h0);
        auto_combo = 1'b0;
        check_eq("combo_redirect_hit", 32'(combo_hit), 32'd1);
        repeat (20) step(1'b0, 32'h0);

        // Random traffic with random redirects (some misaligned, some near the wrap point).
        for (int blk = 0; blk < 30; blk++) begin
            p_ready = int'($urandom_range(30, 100));
            p_ifr   = int'($urandom_range(20, 100));
            lat_min = 1;
            lat_max = int'($urandom_range(1, 5));
            for (int i = 0; i < 100; i++) begin
                tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_3FFF);
                step($urandom_range(99) < 4, tgt);
            end
        end

        // Reset in the middle of traffic; fetch must restart cleanly from the reset PC.
        p_ready = 100; p_ifr = 100; lat_min = 1; lat_max = 2;
        do_reset();
        pops_before = pops;
        repeat (20) step(1'b0, 32'h0);
        check_eq("post_reset_delivery", 32'(pops > pops_before + 3), 32'd1);
        check_eq("liveness", 32'(pops > 200), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
